// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the Sudoku tile controllers.
//   tile_state_e : requester FSM states.
//   collides     : nonzero overlap between a candidate value and an occupancy mask.
//   onehot_last  : true when a one-hot index sits on the last pool position.
// Helpers take MaxLen-bit arguments; callers zero-extend narrower vectors.
package sudoku_pkg;

   localparam int unsigned MaxLen = 32;

   typedef enum logic [1:0] {IDLE, REQ, CHECK, HOLD} tile_state_e;

   function automatic logic collides(input logic [MaxLen-1:0] value,
                                     input logic [MaxLen-1:0] mask);
      return |(value & mask);
   endfunction

   function automatic logic onehot_last(input logic [MaxLen-1:0] idx,
                                        input int unsigned       w);
      return |(idx & (MaxLen'(1) << (w - 1)));
   endfunction

endpackage

// File: rtl/def_griddimensions.sv
// Grid dimension defaults shared by the Sudoku tile logic.
//   GRID_LEN : grid length (values, masks and indices are GRID_LEN bits wide).
// Guarded so that a command-line definition takes precedence.
`ifndef GRID_LEN
`define GRID_LEN 4
`endif

// File: rtl/tile_requester.sv
// Requester-side controller for one Sudoku tile on the shared row-bias bus.
// Walks a one-hot index through the row's value pool, requests each candidate
// from the row bias and commits the first one that misses the column/block
// occupancy. In HOLD, 'back' rejects the commit and resumes the walk.
//
// Ports:
//   clock    : rising-edge clock
//   reset    : synchronous, active-high
//   enable   : start a fresh search (IDLE only)
//   back     : reject committed value and resume (HOLD only)
//   occupied : OR of values taken in this tile's column and block
//   busvalue : row-bias value, valid the cycle after 'update'
//   rqindex  : one-hot pool index, zero when idle
//   update   : one-cycle strobe asking the row bias to latch 'rqindex'
//   value    : committed one-hot value, zero when nothing committed
//   done     : one-cycle pulse on commit
//   fail     : one-cycle pulse when the pool is exhausted
//   attempts : REQ cycles of the current search, saturating at w
//              (present only when TILE_REQUESTER_ATTEMPTS_EN is defined)
`include "def_griddimensions.sv"

module tile_requester
   import sudoku_pkg::*;
#(
   parameter int unsigned w = `GRID_LEN
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         back,
   input  logic [w-1:0] occupied,
   input  logic [w-1:0] busvalue,
   output logic [w-1:0] rqindex,
   output logic         update,
   output logic [w-1:0] value,
   output logic         done,
   output logic         fail
`ifdef TILE_REQUESTER_ATTEMPTS_EN
   ,
   output logic [$clog2(w+1)-1:0] attempts
`endif
);

   tile_state_e  state_q, state_d;
   logic [w-1:0] rqindex_q, rqindex_d;
   logic [w-1:0] value_q, value_d;
   logic         done_q, done_d;
   logic         fail_q, fail_d;
   logic         advance;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         rqindex_q <= '0;
         value_q   <= '0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rqindex_q <= rqindex_d;
         value_q   <= value_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
      end
   end

   // Next-state and index logic
   always_comb begin
      state_d   = state_q;
      rqindex_d = rqindex_q;
      value_d   = value_q;
      done_d    = 1'b0;
      fail_d    = 1'b0;
      advance   = 1'b0;

      unique case (state_q)
         IDLE: begin
            rqindex_d = '0;
            value_d   = '0;
            if (enable) begin
               rqindex_d = {{(w-1){1'b0}}, 1'b1};
               state_d   = REQ;
            end
         end
         REQ: begin
            state_d = CHECK;
         end
         CHECK: begin
            // A zero bus value misses every mask and is committed as-is.
            if (!collides(MaxLen'(busvalue), MaxLen'(occupied))) begin
               value_d = busvalue;
               done_d  = 1'b1;
               state_d = HOLD;
            end else begin
               advance = 1'b1;
            end
         end
         HOLD: begin
            // Backtrack frees the value first, then steps like a collision.
            if (back) begin
               value_d = '0;
               advance = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (advance) begin
         if (onehot_last(MaxLen'(rqindex_q), w)) begin
            rqindex_d = '0;
            value_d   = '0;
            fail_d    = 1'b1;
            state_d   = IDLE;
         end else begin
            rqindex_d = rqindex_q << 1;
            state_d   = REQ;
         end
      end
   end

   // Outputs
   always_comb begin
      update  = (state_q == REQ);
      rqindex = rqindex_q;
      value   = value_q;
      done    = done_q;
      fail    = fail_q;
   end

`ifdef TILE_REQUESTER_ATTEMPTS_EN
   localparam int unsigned AttW = $clog2(w + 1);

   logic [AttW-1:0] attempts_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         attempts_q <= '0;
      end else if (state_q == IDLE && enable) begin
         attempts_q <= '0;
      end else if (state_q == REQ && attempts_q != AttW'(w)) begin
         attempts_q <= attempts_q + 1'b1;
      end
   end

   assign attempts = attempts_q;
`endif

   rqindex_onehot0_a : assert property (@(posedge clock) $onehot0(rqindex_q));

   // The row bias never answers a one-hot request with zero.
   busvalue_nonzero_a : assert property (@(posedge clock) disable iff (reset)
      (state_q == CHECK) |-> (busvalue != '0));

endmodule

// File: doc/tile_requester.md
# tile_requester

Requester-side controller for one Sudoku tile on a shared row-bias bus. Walks a one-hot request index through the row's shuffled value pool, asks the row bus for each candidate, and commits the first candidate that does not collide with the values already occupied in the tile's column and block. On command it resumes the walk from the committed candidate (backtrack) and reports exhaustion when no index remains.

## Interface
- `w`, default `` `GRID_LEN ``: grid length; width of every value, mask and index.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: start a fresh search; sampled in IDLE only.
- `back` in 1: reject the committed value and resume the search; sampled in HOLD only.
- `occupied` in w: OR of the values already taken in this tile's column and block; stable while searching.
- `busvalue` in w: row-bias bus value; valid the cycle after `update` is asserted.
- `rqindex` out w: one-hot pool index, or zero for "no request".
- `update` out 1: one-cycle strobe that tells the row bias to latch the value at `rqindex`.
- `value` out w: committed one-hot value; zero when nothing is committed.
- `done` out 1: one-cycle pulse when `value` is committed.
- `fail` out 1: one-cycle pulse when the pool is exhausted.

## Operation
- States are IDLE, REQ, CHECK and HOLD.
- IDLE:
  - `rqindex` = 0, `value` = 0.
  - `enable` = 1 loads `rqindex` = 1 and moves to REQ.
- REQ:
  - `update` = 1 for exactly this cycle, with `rqindex` stable.
  - Always moves to CHECK.
- CHECK: compare `busvalue & occupied`.
  - Zero: `value` ← `busvalue`, pulse `done`, move to HOLD.
  - Nonzero and `rqindex[w-1]` = 0: `rqindex` ← `rqindex << 1`, move to REQ.
  - Nonzero and `rqindex[w-1]` = 1: `rqindex` ← 0, `value` ← 0, pulse `fail`, move to IDLE.
- HOLD:
  - `value` and `rqindex` are held.
  - `back` = 1 clears `value` to 0 (zero-value on the row bus), then advances exactly as for a collision: shift and go to REQ, or `fail` and go to IDLE if `rqindex[w-1]` = 1.
- Ignored inputs:
  - `enable` outside IDLE.
  - `back` outside HOLD.
  - In HOLD, `back` wins over any `enable`.
- A `busvalue` of zero counts as a non-collision and is committed. The row bias never returns zero for a nonzero one-hot request, so this path flags a protocol error in verification (assertion).
- `occupied` is all ones: every candidate collides, and `fail` fires after w attempts.
- `rqindex` is always zero or exactly one-hot (assertion).

## Timing
- Reset values: state IDLE; `rqindex`, `value`, `update`, `done`, `fail` all 0.
- Reset in any state returns to IDLE on the next edge, mid-search included. No `done` or `fail` pulse is emitted for the aborted search.
- Each candidate costs 2 cycles (REQ, then CHECK).
- `enable` sampled at edge 0 gives:
  - REQ in cycle 1;
  - CHECK in cycle 2;
  - `done` and a valid `value` in cycle 3 at best;
  - `done` or `fail` in cycle 2w+1 at worst.
- `back` sampled at edge k gives REQ in cycle k+1.
- `done` and `fail` are registered, mutually exclusive, and each lasts one cycle.
- `value` is valid from the `done` cycle until `back` or `reset`.

## Configuration
- `TILE_REQUESTER_ATTEMPTS_EN`:
  - Defined: adds output port `attempts` [$clog2(w+1)-1:0]. It resets to 0, clears on an IDLE→REQ transition, and increments once per REQ cycle. Its value is frozen in HOLD and IDLE until the next search. It saturates at w.
  - Undefined: no port and no counter logic; all other behaviour is identical.

## Structure
- Shared package `sudoku_pkg`:
  - `tile_state_e` enum (IDLE, REQ, CHECK, HOLD);
  - function `collides(value, mask)`;
  - function `onehot_last(idx, w)`.
- `w` keeps its default from `` `GRID_LEN `` in `def_griddimensions.sv`.
- Single module, no sub-module. The next-state/index logic is small enough to stay inline.

## Test plan
All scenarios use w=4 and a behavioural row-bias model with pool {0100, 0001, 1000, 0010}.
- Hit on first candidate: `occupied`=0000, `enable` at edge 0 → `update` in cycle 1, `done` in cycle 3, `value`=0100, `rqindex`=0001.
- Skip two collisions: `occupied`=0101 → `done` in cycle 7, `value`=1000, `rqindex`=0100, 3 `update` strobes.
- Exhaustion: `occupied`=1111 → 4 `update` strobes, `fail` in cycle 9, `rqindex`=0000, `value`=0000.
- Backtrack: commit 0100, then assert `back` → `value`=0000 next cycle; `occupied`=0100 gives `done` with `value`=0001. A second `back` with `occupied`=1101 gives 0010. A third `back` gives `fail`.
- Reset mid-CHECK → all outputs 0 next cycle and no `done`/`fail`. A following `enable` restarts at `rqindex`=0001.
- `TILE_REQUESTER_ATTEMPTS_EN` build: rerun the skip and exhaustion scenarios → `attempts`=3 and `attempts`=4 respectively.
